// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding, BCD nibble geometry and the reverse double-dabble
// correction constants, plus a small digit-validity helper.
package bcd_to_bin_seq_pkg;

    localparam int NIBBLE_W = 4;

    // After a right shift, a nibble holding 8 or more received a carried-in
    // bit worth 8 that is really worth 5 in decimal, so 3 is taken off.
    localparam logic [NIBBLE_W-1:0] BCD_THRESH = 4'd8;
    localparam logic [NIBBLE_W-1:0] BCD_ADJUST = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic nibble_invalid(input logic [NIBBLE_W-1:0] n);
        return n > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/response bundle between an operand source and the converter.
//
// Handshake: the source raises start with bcd_in stable; the converter takes
// it only while idle (busy=0) and ignores start at every other time. busy is
// high from the cycle after acceptance through the done cycle. done is a
// one-cycle pulse; result, err_digit and over_max are valid with it and hold
// until the next accepted conversion completes. state mirrors the FSM for
// observation only.
//
// master : drives start, bcd_in; observes everything else
// slave  : the converter side
interface bcd_to_bin_seq_if
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) ();

    logic                       start;
    logic [NIBBLE_W*DIGITS-1:0] bcd_in;
    logic                       busy;
    logic                       done;
    logic [BIN_W-1:0]           result;
    logic                       err_digit;
    logic                       over_max;
    state_t                     state;

    modport master (
        output start, bcd_in,
        input  busy, done, result, err_digit, over_max, state
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, result, err_digit, over_max, state
    );

endinterface

// File: rtl/bcd_to_bin_seq_bcd_nibble_adjust.sv
// One BCD digit correction stage of the reverse double-dabble:
// din  : nibble after the right shift
// dout : din - 3 when din >= 8, otherwise din unchanged
module bcd_nibble_adjust
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] din,
    output logic [NIBBLE_W-1:0] dout
);

    assign dout = (din >= BCD_THRESH) ? (din - BCD_ADJUST) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift/correct step per clock, BIN_W steps per conversion.
//
// clk : rising-edge clock
// rst : asynchronous active-high reset, aborts any conversion in progress
// bus : slave side of bcd_to_bin_seq_if (start, bcd_in in; busy, done,
//       result, err_digit, over_max, state out)
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS  = 3,
    parameter int BIN_W   = 10,
    parameter int MAX_VAL = 255
) (
    input  logic              clk,
    input  logic              rst,
    bcd_to_bin_seq_if.slave   bus
);

    localparam int BCD_W  = NIBBLE_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int STEP_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0]  MAX_VAL_W = BIN_W'(MAX_VAL);

    state_t            state_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BIN_W-1:0]  bin_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q;
    logic              done_q;
    logic [BIN_W-1:0]  result_q;
    logic              err_q;
    logic              over_q;

    logic              any_bad;
    logic [WORK_W-1:0] shifted;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BIN_W-1:0]  bin_next;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            any_bad = any_bad | nibble_invalid(bus.bcd_in[NIBBLE_W*i +: NIBBLE_W]);
        end
    end

    // The BCD LSB falls into the binary MSB; the binary LSB of the previous
    // step has already been final since the step it arrived.
    assign shifted  = {bcd_q, bin_q} >> 1;
    assign bin_next = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .din  (shifted[BIN_W + NIBBLE_W*g +: NIBBLE_W]),
            .dout (bcd_adj[NIBBLE_W*g +: NIBBLE_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (any_bad) begin
                            // Bad digit: report immediately, nothing to shift.
                            err_q    <= 1'b1;
                            result_q <= '0;
                            over_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            bcd_q   <= bus.bcd_in;
                            bin_q   <= '0;
                            step_q  <= '0;
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    bcd_q  <= bcd_adj;
                    bin_q  <= bin_next;
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        result_q <= bin_next;
                        err_q    <= 1'b0;
                        over_q   <= (bin_next > MAX_VAL_W);
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.err_digit = err_q;
    assign bus.over_max  = over_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;
    import bcd_to_bin_seq_pkg::*;

    logic clk;
    logic rst;

    int n_vec = 0;
    int n_bad = 0;

    // {err_digit, over_max, result[9:0]}
    logic [11:0] exp_q[$];

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10), .MAX_VAL(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [11:0] model(input logic [11:0] b);
        int d0, d1, d2, v;
        d0 = int'(b[3:0]);
        d1 = int'(b[7:4]);
        d2 = int'(b[11:8]);
        if (d0 > 9 || d1 > 9 || d2 > 9) return {1'b1, 1'b0, 10'd0};
        v = d2 * 100 + d1 * 10 + d0;
        return {1'b0, (v > 255), 10'(v)};
    endfunction

    // ---------------- driver ----------------
    // Presents bcd during one cycle (cycle 0), then counts cycles 1,2,...
    // sampling at the falling edge. lat = cycle index of done, -1 on timeout.
    task automatic drive_conv(input logic [11:0] bcd, output logic [11:0] obs,
                              output int lat, output int busy_cycles);
        exp_q.push_back(model(bcd));
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(negedge clk);
        bus.start   = 1'b0;
        lat         = -1;
        busy_cycles = 0;
        obs         = '0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = i;
                obs = {bus.err_digit, bus.over_max, bus.result};
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.busy, bus.done, bus.err_digit, bus.over_max, bus.result} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b over=%b result=%0d, want all 0",
                     bus.busy, bus.done, bus.err_digit, bus.over_max, bus.result);
        end
        n_vec++;
        if (bus.state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [11:0] obs, exp;
        int lat, bc;
        drive_conv(12'h000, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL zero_value: got %h want %h", obs, exp);
        end
        n_vec++;
        if (lat !== 11) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d want 11", lat);
        end
        n_vec++;
        if (bc !== 11) begin
            n_bad++;
            $display("FAIL zero_busy_cycles: got %0d want 11", bc);
        end
    endtask

    task automatic test_limit();
        logic [11:0] obs, exp;
        int lat, bc;
        drive_conv(12'h255, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || obs !== {1'b0, 1'b0, 10'd255}) begin
            n_bad++;
            $display("FAIL limit_255: got %h want %h", obs, {1'b0, 1'b0, 10'd255});
        end
        drive_conv(12'h256, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || obs !== {1'b0, 1'b1, 10'd256}) begin
            n_bad++;
            $display("FAIL limit_256: got %h want %h", obs, {1'b0, 1'b1, 10'd256});
        end
        drive_conv(12'h999, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== {1'b0, 1'b1, 10'h3E7} || lat !== 11) begin
            n_bad++;
            $display("FAIL full_range_999: got %h lat %0d want %h lat 11", obs, lat, exp);
        end
    endtask

    task automatic test_sweep();
        logic [11:0] obs, exp, b;
        int lat, bc;
        for (int d2 = 0; d2 < 10; d2++) begin
            for (int d1 = 0; d1 < 10; d1++) begin
                for (int d0 = 0; d0 < 10; d0++) begin
                    b = {4'(d2), 4'(d1), 4'(d0)};
                    drive_conv(b, obs, lat, bc);
                    exp = exp_q.pop_front();
                    n_vec++;
                    if (obs !== exp || lat !== 11) begin
                        n_bad++;
                        $display("FAIL sweep_%h: got %h lat %0d want %h lat 11", b, obs, lat, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_bad_digit();
        logic [11:0] obs, exp, b;
        int lat, bc, pos;
        drive_conv(12'h1A3, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || obs !== {1'b1, 1'b0, 10'd0}) begin
            n_bad++;
            $display("FAIL bad_1A3_value: got %h want %h", obs, {1'b1, 1'b0, 10'd0});
        end
        n_vec++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL bad_1A3_latency: got %0d want 1", lat);
        end
        drive_conv(12'h005, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || obs[11] !== 1'b0) begin
            n_bad++;
            $display("FAIL err_cleared: got %h want %h", obs, exp);
        end
        for (int k = 0; k < 8; k++) begin
            b   = 12'($urandom_range(0, 4095));
            pos = $urandom_range(0, 2);
            b[4*pos +: 4] = 4'($urandom_range(10, 15));
            drive_conv(b, obs, lat, bc);
            exp = exp_q.pop_front();
            n_vec++;
            if (obs !== exp || lat !== 1) begin
                n_bad++;
                $display("FAIL bad_random_%h: got %h lat %0d want %h lat 1", b, obs, lat, exp);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [11:0] obs, exp;
        int done_cnt, first_done;
        exp_q.push_back(model(12'h042));
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h042;
        done_cnt   = 0;
        first_done = -1;
        obs        = '0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            bus.start  = (i == 3 || i == 10);
            bus.bcd_in = (i == 3 || i == 10) ? 12'h777 : 12'h042;
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = i;
                    obs = {bus.err_digit, bus.over_max, bus.result};
                end
            end
        end
        bus.start = 1'b0;
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || first_done !== 11) begin
            n_bad++;
            $display("FAIL ignore_start_value: got %h at %0d want %h at 11", obs, first_done, exp);
        end
        n_vec++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL ignore_start_pulses: got %0d done pulses want 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h321;
        d1 = -1;
        d2 = -1;
        n  = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n++;
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
                n_vec++;
                if (bus.result !== 10'd321) begin
                    n_bad++;
                    $display("FAIL b2b_value: got %0d want 321", bus.result);
                end
            end
        end
        bus.start = 1'b0;
        n_vec++;
        if (d1 !== 11 || d2 !== 23) begin
            n_bad++;
            $display("FAIL b2b_timing: got done at %0d,%0d want 11,23", d1, d2);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [11:0] obs, exp;
        int lat, bc, done_cnt;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        @(negedge clk);
        bus.start = 1'b0;
        done_cnt  = 0;
        for (int i = 1; i < 5; i++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.err_digit, bus.over_max, bus.result} !== 14'd0 ||
            bus.state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b err=%b over=%b result=%0d state=%0d want all 0",
                     bus.busy, bus.done, bus.err_digit, bus.over_max, bus.result, bus.state);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        n_vec++;
        if (done_cnt !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt);
        end
        drive_conv(12'h128, obs, lat, bc);
        exp = exp_q.pop_front();
        n_vec++;
        if (obs !== exp || obs !== {1'b0, 1'b0, 10'd128} || lat !== 11) begin
            n_bad++;
            $display("FAIL after_abort_128: got %h lat %0d want %h lat 11", obs, lat, exp);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero();
        test_limit();
        test_bad_digit();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential decimal-to-binary converter. It converts operator-entered decimal digits (packed BCD) into the binary operand that feeds the 8-bit accumulator datapath. It is the inverse of the binary-to-decimal digit extraction that drives the HEX displays. It uses an iterative reverse double-dabble: one shift/correct step per clock, with a start/busy/done handshake.

Parameters:
DIGITS, 3, number of BCD digits in bcd_in
BIN_W, 10, result width; must satisfy 2^BIN_W > 10^DIGITS - 1; also the number of iteration cycles
MAX_VAL, 255, range limit for over_max (accumulator operand limit)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0] (ones), most significant digit in top nibble; sampled with start
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse when result/flags valid
result  output  BIN_W  binary value; holds until next accepted start
err_digit  output  1  some nibble of sampled bcd_in > 9; valid with done, held
over_max  output  1  result > MAX_VAL; valid with done, held

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, err_digit=0, over_max=0, shift register and step counter cleared. Reset mid-conversion aborts the conversion; no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE + start=1:
  - Check all nibbles of bcd_in.
  - If any nibble > 9: err_digit=1, result=0, over_max=0, go to DONE. No shifting.
  - Otherwise: load working register {bcd_part[4*DIGITS], bin_part[BIN_W]} = {bcd_in, 0}; step=0; err_digit=0; go to SHIFT.
- SHIFT, each cycle:
  - Logically shift the whole working register right by 1. The bcd LSB moves into the bin MSB.
  - Then, for every BCD nibble whose value is >= 8 after the shift, subtract 3.
  - step increments. When step reaches BIN_W-1 on this cycle, go to DONE.
- DONE (exactly one cycle):
  - done=1. result=bin_part (or 0 if err_digit). over_max = (result > MAX_VAL).
  - Return to IDLE.
- result, err_digit and over_max update only on entry to DONE. Between conversions they hold their last values.
- Latency:
  - Valid digits: start accepted at edge N; done high during cycle N+BIN_W+1 (10 SHIFT cycles + 1 DONE cycle).
  - Invalid digit: done high during cycle N+1.
- start while busy=1 is ignored, including start held high across DONE. A new conversion needs start high in IDLE. Start held continuously restarts back-to-back, one IDLE cycle between conversions.
- Full-range input 10^DIGITS-1 (999) must convert exactly. No internal overflow is permitted, given the BIN_W constraint.
- Simultaneous rst and start: reset wins.

Decomposition:
- Shared package: state encoding (IDLE/SHIFT/DONE), BCD nibble width constant (4), BCD correction constants (threshold 8, adjust 3).
- One natural sub-module: bcd_nibble_adjust (combinational; 4-bit in, subtract 3 if >= 8), instantiated DIGITS times by generate.
- The step counter and FSM stay in the top module.

Test Plan:
1. Reset, then bcd_in=12'h000, start pulse -> done exactly 11 cycles later; result=0, err_digit=0, over_max=0; busy high for those 11 cycles.
2. bcd_in=12'h255 -> result=255, over_max=0. Then bcd_in=12'h256 -> result=256, over_max=1.
3. bcd_in=12'h999 -> result=999 (10'h3E7), over_max=1. Sweep all 1000 valid inputs and compare result against a reference model.
4. bcd_in=12'h1A3 -> done 1 cycle after start; err_digit=1, result=0. The next valid start clears err_digit.
5. Assert start again at cycles 3 and 10 of a running conversion of 12'h042 -> ignored; result=42 at the original done time; no second done pulse.
6. Assert rst at SHIFT cycle 5 of 12'h777 -> all outputs 0 immediately, no done pulse. A following start with 12'h128 -> result=128 after 11 cycles.
